// File: rtl/ping_burst_gen.sv
// Sonar transmit sequencer: gated carrier bursts with blanking, listen window
// and repetition timing, plus a free-running continuous tone mode.
module ping_burst_gen #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16,
    parameter int PRI_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic [DIV_W-1:0] half_period,
    input  logic [CNT_W-1:0] burst_cycles,
    input  logic [CNT_W-1:0] blank_cycles,
    input  logic [PRI_W-1:0] interval,
    output logic             speaker,
    output logic             tx_active,
    output logic             rx_window,
    output logic             burst_start,
    output logic             burst_done,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TONE,
        S_BURST,
        S_BLANK,
        S_LISTEN
    } state_t;

    state_t state_q, state_d;

    logic [DIV_W-1:0] hp_q, hp_d, hc_q, hc_d;
    logic [CNT_W-1:0] nb_q, nb_d, nk_q, nk_d, cc_q, cc_d, bc_q, bc_d;
    logic [PRI_W-1:0] iv_q, iv_d, t_q, t_d;
    logic [1:0]       mode_q, mode_d;
    logic             speaker_q, speaker_d;
    logic             bstart_q, bstart_d;
    logic             bdone_q, bdone_d;

    logic             hc_wrap;
    logic [CNT_W-1:0] nb_eff;
    logic             burst_end;
    logic             blank_end;
    logic [PRI_W:0]   t_plus1;
    logic             listen_end;
    logic [PRI_W-1:0] t_inc;
    logic             burst_req;

    assign hc_wrap    = (hc_q == hp_q);
    assign nb_eff     = (nb_q == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : nb_q;
    // The burst ends only once the low half after the last counted 1->0 edge completes.
    assign burst_end  = hc_wrap && !speaker_q && (cc_q == nb_eff);
    assign blank_end  = (bc_q == nk_q - 1'b1);
    assign t_plus1    = {1'b0, t_q} + {{PRI_W{1'b0}}, 1'b1};
    assign listen_end = (t_plus1 >= {1'b0, iv_q});
    assign t_inc      = (&t_q) ? t_q : t_q + 1'b1;
    assign burst_req  = (mode == 2'd1) || (mode == 2'd2);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (start) state_d = burst_req ? S_BURST : S_TONE;
                S_TONE:   state_d = S_TONE;
                S_BURST:  if (burst_end) state_d = (nk_q == '0) ? S_LISTEN : S_BLANK;
                S_BLANK:  if (blank_end) state_d = S_LISTEN;
                S_LISTEN: if (listen_end) state_d = (mode_q == 2'd2) ? S_BURST : S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Datapath next values, keyed on the state being entered
    always_comb begin
        hp_d      = hp_q;
        nb_d      = nb_q;
        nk_d      = nk_q;
        iv_d      = iv_q;
        hc_d      = hc_q;
        cc_d      = cc_q;
        bc_d      = bc_q;
        t_d       = t_q;
        mode_d    = mode_q;
        speaker_d = speaker_q;
        bstart_d  = 1'b0;
        bdone_d   = 1'b0;

        if (state_q == S_IDLE && state_d != S_IDLE) begin
            mode_d = mode;
        end

        case (state_d)
            S_IDLE: begin
                speaker_d = 1'b0;
                hc_d      = '0;
                cc_d      = '0;
                bc_d      = '0;
                t_d       = '0;
            end
            S_TONE: begin
                if (state_q != S_TONE) begin
                    // The tone has no BURST entry, so it picks up its period here.
                    hp_d      = half_period;
                    hc_d      = '0;
                    speaker_d = 1'b1;
                end else if (hc_wrap) begin
                    hc_d      = '0;
                    speaker_d = ~speaker_q;
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            S_BURST: begin
                if (state_q != S_BURST) begin
                    hp_d      = half_period;
                    nb_d      = burst_cycles;
                    nk_d      = blank_cycles;
                    iv_d      = interval;
                    hc_d      = '0;
                    cc_d      = '0;
                    t_d       = '0;
                    speaker_d = 1'b1;
                    bstart_d  = 1'b1;
                end else begin
                    t_d = t_inc;
                    if (hc_wrap) begin
                        hc_d      = '0;
                        speaker_d = ~speaker_q;
                        if (speaker_q) cc_d = cc_q + 1'b1;
                    end else begin
                        hc_d = hc_q + 1'b1;
                    end
                end
            end
            S_BLANK: begin
                speaker_d = 1'b0;
                t_d       = t_inc;
                bdone_d   = (state_q == S_BURST);
                bc_d      = (state_q == S_BURST) ? '0 : bc_q + 1'b1;
            end
            S_LISTEN: begin
                speaker_d = 1'b0;
                t_d       = t_inc;
                bdone_d   = (state_q == S_BURST);
            end
            default: begin
                speaker_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hp_q      <= '0;
            nb_q      <= '0;
            nk_q      <= '0;
            iv_q      <= '0;
            hc_q      <= '0;
            cc_q      <= '0;
            bc_q      <= '0;
            t_q       <= '0;
            mode_q    <= '0;
            speaker_q <= 1'b0;
            bstart_q  <= 1'b0;
            bdone_q   <= 1'b0;
        end else begin
            hp_q      <= hp_d;
            nb_q      <= nb_d;
            nk_q      <= nk_d;
            iv_q      <= iv_d;
            hc_q      <= hc_d;
            cc_q      <= cc_d;
            bc_q      <= bc_d;
            t_q       <= t_d;
            mode_q    <= mode_d;
            speaker_q <= speaker_d;
            bstart_q  <= bstart_d;
            bdone_q   <= bdone_d;
        end
    end

    // Output logic
    always_comb begin
        speaker     = speaker_q;
        burst_start = bstart_q;
        burst_done  = bdone_q;
        tx_active   = (state_q == S_TONE) || (state_q == S_BURST);
        rx_window   = (state_q == S_LISTEN);
        busy        = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_ping_burst_gen.sv
// Bench for ping_burst_gen: directed and randomized pings compared cycle by
// cycle against a timeline model built from burst/blank/listen durations.
module tb_ping_burst_gen;
    localparam int DIV_W = 16;
    localparam int CNT_W = 16;
    localparam int PRI_W = 24;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic             start = 1'b0;
    logic [DIV_W-1:0] half_period = '0;
    logic [CNT_W-1:0] burst_cycles = '0;
    logic [CNT_W-1:0] blank_cycles = '0;
    logic [PRI_W-1:0] interval = '0;
    logic speaker, tx_active, rx_window, burst_start, burst_done, busy;

    int vectors = 0;
    int errors  = 0;

    ping_burst_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W), .PRI_W(PRI_W)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .start(start),
        .half_period(half_period), .burst_cycles(burst_cycles),
        .blank_cycles(blank_cycles), .interval(interval),
        .speaker(speaker), .tx_active(tx_active), .rx_window(rx_window),
        .burst_start(burst_start), .burst_done(burst_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {speaker, tx_active, rx_window, burst_start, burst_done, busy}
    function automatic logic [5:0] obs();
        return {speaker, tx_active, rx_window, burst_start, burst_done, busy};
    endfunction

    function automatic int burst_len(int hp, int nb);
        return 2 * (hp + 1) * ((nb == 0) ? 1 : nb);
    endfunction

    // Last ping-relative cycle of LISTEN: at least one listen cycle, else when t reaches iv-1.
    function automatic int listen_last(int hp, int nb, int nk, int iv);
        int a;
        a = burst_len(hp, nb) + nk;
        return (a > iv - 1) ? a : iv - 1;
    endfunction

    function automatic logic [5:0] ping_exp(int k, int hp, int nb, int nk, int iv);
        int L;
        L = burst_len(hp, nb);
        if (k < L)
            return {((k / (hp + 1)) % 2 == 0), 1'b1, 1'b0, (k == 0), 1'b0, 1'b1};
        else if (k < L + nk)
            return {1'b0, 1'b0, 1'b0, 1'b0, (k == L), 1'b1};
        else if (k <= listen_last(hp, nb, nk, iv))
            return {1'b0, 1'b0, 1'b1, 1'b0, (k == L), 1'b1};
        return 6'b0;
    endfunction

    task automatic set_cfg(int hp, int nb, int nk, int iv);
        half_period  = DIV_W'(hp);
        burst_cycles = CNT_W'(nb);
        blank_cycles = CNT_W'(nk);
        interval     = PRI_W'(iv);
    endtask

    task automatic test_reset();
        logic [5:0] o;
        reset_n = 1'b0;
        enable  = 1'b1;
        tick();
        o = obs();
        vectors++;
        if (o !== 6'b0) begin
            errors++;
            $display("FAIL reset_held got=%b want=000000", o);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            o = obs();
            vectors++;
            if (o !== 6'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b want=000000", i, o);
            end
        end
        $display("reset: outputs idle after reset and release");
    endtask

    // Runs npings pings in mode md; optional half_period change during ping 0 and
    // an extra start pulse in the first LISTEN cycle of each ping.
    task automatic run_pings(string tag, int md, int npings, int new_hp, bit start_in_listen);
        int hp, nb, nk, iv, last, L;
        logic [5:0] o, e;
        mode  = 2'(md);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < npings; p++) begin
            hp   = int'(half_period);
            nb   = int'(burst_cycles);
            nk   = int'(blank_cycles);
            iv   = int'(interval);
            L    = burst_len(hp, nb);
            last = listen_last(hp, nb, nk, iv);
            for (int k = 0; k <= last; k++) begin
                o = obs();
                e = ping_exp(k, hp, nb, nk, iv);
                vectors++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL %s ping=%0d k=%0d got=%b want=%b", tag, p, k, o, e);
                end
                if (p == 0 && k == 2 && new_hp >= 0) half_period = DIV_W'(new_hp);
                start = (start_in_listen && k == L + nk);
                tick();
            end
            start = 1'b0;
            $display("%s: ping %0d mode=%0d hp=%0d nb=%0d nk=%0d iv=%0d len=%0d",
                     tag, p, md, hp, nb, nk, iv, last + 1);
        end
        if (md == 2) begin
            e = ping_exp(0, int'(half_period), int'(burst_cycles),
                         int'(blank_cycles), int'(interval));
            o = obs();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s next_start got=%b want=%b", tag, o, e);
            end
            enable = 1'b0;
            tick();
            enable = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            o = obs();
            vectors++;
            if (o !== 6'b0) begin
                errors++;
                $display("FAIL %s idle_after cyc=%0d got=%b want=000000", tag, i, o);
            end
            tick();
        end
    endtask

    task automatic test_continuous(int hp, int ncyc);
        logic [5:0] o, e;
        half_period = DIV_W'(hp);
        mode  = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= ncyc; k++) begin
            o = obs();
            e = {((k / (hp + 1)) % 2 == 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL tone hp=%0d k=%0d got=%b want=%b", hp, k, o, e);
            end
            start = (k == 4);
            if (k == 6) half_period = DIV_W'(hp + 3);
            tick();
        end
        half_period = DIV_W'(hp);
        enable = 1'b0;
        tick();
        o = obs();
        vectors++;
        if (o !== 6'b0) begin
            errors++;
            $display("FAIL tone_disable got=%b want=000000", o);
        end
        enable = 1'b1;
        tick();
        $display("tone: hp=%0d mode=%0d %0d cycles then disabled", hp, mode, ncyc + 1);
    endtask

    // Disable on the last BURST cycle: no burst_done and outputs cleared next cycle.
    task automatic test_disable();
        int hp, L;
        logic [5:0] o, e;
        hp = $urandom_range(0, 3);
        set_cfg(hp, 2, 3, 40);
        L = burst_len(hp, 2);
        mode  = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < L; k++) begin
            o = obs();
            e = ping_exp(k, hp, 2, 3, 40);
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL disable_burst k=%0d got=%b want=%b", k, o, e);
            end
            if (k == L - 1) enable = 1'b0;
            tick();
        end
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            o = obs();
            vectors++;
            if (o !== 6'b0) begin
                errors++;
                $display("FAIL disable_idle cyc=%0d got=%b want=000000", i, o);
            end
            tick();
        end
        $display("disable: periodic ping abandoned on last burst cycle hp=%0d", hp);
    endtask

    task automatic test_async_reset();
        logic [5:0] o;
        set_cfg(7, 4, 10, 200);
        mode  = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        o = obs();
        vectors++;
        if (o !== 6'b110001) begin
            errors++;
            $display("FAIL areset_pre got=%b want=110001", o);
        end
        #2;
        reset_n = 1'b0;
        #1;
        o = obs();
        vectors++;
        if (o !== 6'b0) begin
            errors++;
            $display("FAIL areset_immediate got=%b want=000000", o);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            o = obs();
            vectors++;
            if (o !== 6'b0) begin
                errors++;
                $display("FAIL areset_idle cyc=%0d got=%b want=000000", i, o);
            end
        end
        $display("async_reset: cleared mid-burst, idle after release");
    endtask

    task automatic test_random(int n);
        int md;
        for (int i = 0; i < n; i++) begin
            set_cfg($urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 6), $urandom_range(0, 70));
            md = $urandom_range(1, 2);
            run_pings("random", md, (md == 2) ? 2 : 1, -1, $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        test_reset();
        set_cfg(7, 4, 10, 200);
        run_pings("single", 1, 1, -1, 1'b0);
        set_cfg(7, 4, 10, 200);
        run_pings("periodic", 2, 3, 3, 1'b0);
        set_cfg(7, 4, 10, 20);
        run_pings("short_iv", 2, 2, -1, 1'b0);
        test_continuous(0, 12);
        test_continuous($urandom_range(1, 4), 20);
        set_cfg(2, 0, 0, 5);
        run_pings("edge_nb0_nk0", 1, 1, -1, 1'b1);
        set_cfg(1, 2, 0, 30);
        run_pings("edge_listen_start", 2, 2, -1, 1'b1);
        test_disable();
        test_random(8);
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end
endmodule
